// File: rtl/ofs_pcie_ss_rd_req_splitter.sv
// Read request splitter: breaks a large dword-aligned read into chunks that
// never cross a MAX_RD_REQ_BYTES boundary, tagging each chunk from a pool of
// NUM_TAGS PCIe tags that are returned by the completion path.
module ofs_pcie_ss_rd_req_splitter #(
  parameter int MAX_RD_REQ_BYTES = 512,
  parameter int NUM_TAGS         = 128,
  parameter int ADDR_WIDTH       = 64,
  parameter int LEN_WIDTH        = 24,
  localparam int TAG_W  = $clog2(NUM_TAGS),
  localparam int OLEN_W = $clog2(MAX_RD_REQ_BYTES) + 1,
  localparam int CNT_W  = $clog2(NUM_TAGS) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [LEN_WIDTH-1:0]  in_len,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [OLEN_W-1:0]     out_len,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  out_last,
  input  logic                  cpl_valid,
  input  logic [TAG_W-1:0]      cpl_tag,
  output logic [CNT_W-1:0]      tags_free,
  output logic                  err_dbl_free
);

  localparam int OFF_W = $clog2(MAX_RD_REQ_BYTES);

  typedef enum logic {IDLE, SPLIT} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [NUM_TAGS-1:0]   tag_busy;

  logic [OFF_W-1:0]      boundary_off;
  logic [OLEN_W-1:0]     room;
  logic [OLEN_W-1:0]     chunk_len;
  logic                  chunk_last;
  logic [TAG_W-1:0]      free_tag;
  logic                  can_load;
  logic                  release_ok;
  logic                  release_bad;

  // A new request is only taken while no split is in progress.
  assign in_ready = (state == IDLE) && !reset;

  // The chunk runs to the next MAX_RD_REQ_BYTES boundary or to the end of the
  // request, whichever is nearer; when it is the end, the remainder fits OLEN_W.
  assign boundary_off = cur_addr[OFF_W-1:0];
  assign room         = OLEN_W'(MAX_RD_REQ_BYTES) - OLEN_W'(boundary_off);
  assign chunk_last   = (remaining <= LEN_WIDTH'(room));
  assign chunk_len    = chunk_last ? remaining[OLEN_W-1:0] : room;

  // A chunk is loaded when the output register is free or draining and a tag exists.
  assign can_load    = (state == SPLIT) && (!out_valid || out_ready) && (tags_free != '0);
  assign release_ok  = cpl_valid && tag_busy[cpl_tag];
  assign release_bad = cpl_valid && !tag_busy[cpl_tag];

  // Priority encoder: lowest-numbered tag that is not reserved.
  always_comb begin
    free_tag = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!tag_busy[i]) free_tag = TAG_W'(i);
    end
  end

  // Splitting FSM with the registered chunk output stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_len   <= '0;
      out_tag   <= '0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cur_addr  <= in_addr;
            remaining <= in_len;
            state     <= SPLIT;
          end
        end
        SPLIT: begin
          if (can_load) begin
            cur_addr  <= cur_addr + ADDR_WIDTH'(chunk_len);
            remaining <= remaining - LEN_WIDTH'(chunk_len);
            if (chunk_last) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (can_load) begin
        out_valid <= 1'b1;
        out_addr  <= cur_addr;
        out_len   <= chunk_len;
        out_tag   <= free_tag;
        out_last  <= chunk_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Tag reservation bitmap; a released tag only becomes visible next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_busy <= '0;
    end else begin
      if (release_ok) tag_busy[cpl_tag] <= 1'b0;
      if (can_load) tag_busy[free_tag] <= 1'b1;
    end
  end

  // Free-tag counter; a reserve and a release in the same cycle cancel out.
  always_ff @(posedge clk) begin
    if (reset) begin
      tags_free <= CNT_W'(NUM_TAGS);
    end else begin
      case ({can_load, release_ok})
        2'b10:   tags_free <= tags_free - CNT_W'(1);
        2'b01:   tags_free <= tags_free + CNT_W'(1);
        default: tags_free <= tags_free;
      endcase
    end
  end

  // Sticky flag for a completion that returns a tag nobody holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_dbl_free <= 1'b0;
    end else if (release_bad) begin
      err_dbl_free <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ofs_pcie_ss_rd_req_splitter.sv
// Bench for the read request splitter: a directed table of single requests,
// hand-written tag-exhaustion / hold / reset sequences, and a randomized run,
// all compared against a chunk-list and tag-set model kept in the bench.
module tb_ofs_pcie_ss_rd_req_splitter;

  localparam int MAX_B = 512;
  localparam int NT    = 128;
  localparam int AW    = 64;
  localparam int LW    = 24;
  localparam int TW    = 7;
  localparam int OW    = 10;
  localparam int CW    = 8;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [LW-1:0] in_len;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [OW-1:0] out_len;
  logic [TW-1:0] out_tag;
  logic          out_last;
  logic          cpl_valid;
  logic [TW-1:0] cpl_tag;
  logic [CW-1:0] tags_free;
  logic          err_dbl_free;

  ofs_pcie_ss_rd_req_splitter #(
    .MAX_RD_REQ_BYTES(MAX_B),
    .NUM_TAGS(NT),
    .ADDR_WIDTH(AW),
    .LEN_WIDTH(LW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_addr(in_addr),
    .in_len(in_len),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_addr(out_addr),
    .out_len(out_len),
    .out_tag(out_tag),
    .out_last(out_last),
    .cpl_valid(cpl_valid),
    .cpl_tag(cpl_tag),
    .tags_free(tags_free),
    .err_dbl_free(err_dbl_free)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    longint unsigned addr;
    int              len;
    bit              last;
  } chunk_t;

  typedef struct {
    longint unsigned addr;
    int              len;
    int              n;
    int              first_len;
    int              last_len;
    int              tags_free;
  } vec_t;

  chunk_t exp_q[$];
  bit     busy_m[NT];
  int     reserved_cnt;
  bit     err_m;
  int     checks;
  int     errors;
  bit     last_hs;
  int     obs_n;
  int     obs_first;
  int     obs_last;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Expected chunk list of one request, straight from the boundary rule.
  function automatic void push_request(input longint unsigned a, input int l);
    longint unsigned addr;
    int              rem;
    int              room;
    int              n;
    chunk_t          c;
    addr = a;
    rem  = l;
    while (rem > 0) begin
      room   = MAX_B - int'(addr % longint'(MAX_B));
      n      = (rem < room) ? rem : room;
      c.addr = addr;
      c.len  = n;
      c.last = (n == rem);
      exp_q.push_back(c);
      addr += longint'(n);
      rem  -= n;
    end
  endfunction

  function automatic int lowest_free();
    for (int i = 0; i < NT; i++) begin
      if (!busy_m[i]) return i;
    end
    return -1;
  endfunction

  // One clock cycle: capture what is driven, step the clock, compare against the model.
  task automatic tick();
    logic            pv, pr, rs, cv, hs;
    logic [TW-1:0]   ct;
    logic [AW-1:0]   h_addr;
    logic [LW-1:0]   h_len;
    logic [AW-1:0]   p_addr;
    logic [OW-1:0]   p_len;
    logic [TW-1:0]   p_tag;
    logic            p_last;
    bit              exp_load;
    int              exp_tag;
    chunk_t          c;
    #1;
    pv = out_valid; pr = out_ready; rs = reset; cv = cpl_valid; ct = cpl_tag;
    hs = in_valid && in_ready;
    h_addr = in_addr; h_len = in_len;
    p_addr = out_addr; p_len = out_len; p_tag = out_tag; p_last = out_last;
    exp_load = !rs && (exp_q.size() != 0) && (!pv || pr) && (reserved_cnt < NT);
    exp_tag  = lowest_free();
    last_hs  = hs && !rs;
    @(posedge clk);
    #1;
    if (rs) begin
      foreach (busy_m[i]) busy_m[i] = 1'b0;
      reserved_cnt = 0;
      err_m        = 1'b0;
      exp_q.delete();
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_addr", 64'(out_addr), 64'(0));
      check("rst_out_len", 64'(out_len), 64'(0));
      check("rst_out_tag", 64'(out_tag), 64'(0));
      check("rst_out_last", 64'(out_last), 64'(0));
    end else begin
      check("out_valid", 64'(out_valid), 64'(exp_load || (pv && !pr)));
      if (exp_load) begin
        c = exp_q.pop_front();
        check("chunk_addr", 64'(out_addr), 64'(c.addr));
        check("chunk_len", 64'(out_len), 64'(c.len));
        check("chunk_last", 64'(out_last), 64'(c.last));
        check("chunk_tag", 64'(out_tag), 64'(exp_tag));
        obs_n++;
        if (obs_n == 1) obs_first = c.len;
        obs_last = c.len;
      end else if (pv && !pr) begin
        check("hold_addr", 64'(out_addr), 64'(p_addr));
        check("hold_len", 64'(out_len), 64'(p_len));
        check("hold_tag", 64'(out_tag), 64'(p_tag));
        check("hold_last", 64'(out_last), 64'(p_last));
      end
      if (cv) begin
        if (busy_m[ct]) begin
          busy_m[ct] = 1'b0;
          reserved_cnt--;
        end else begin
          err_m = 1'b1;
        end
      end
      if (exp_load && exp_tag >= 0) begin
        busy_m[exp_tag] = 1'b1;
        reserved_cnt++;
      end
      if (hs) push_request(64'(h_addr), int'(h_len));
    end
    check("tags_free", 64'(tags_free), 64'(NT - reserved_cnt));
    check("err_dbl_free", 64'(err_dbl_free), 64'(err_m));
    check("in_ready", 64'(in_ready), 64'((exp_q.size() == 0) && !reset));
  endtask

  task automatic apply_reset();
    reset = 1'b1; in_valid = 1'b0; cpl_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic drain(input int budget);
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || out_valid) && cyc < budget) begin
      tick();
      cyc++;
    end
    if (cyc >= budget) begin
      errors++;
      $display("[TB] FAIL drain_timeout actual=%0d expected<%0d", cyc, budget);
    end
  endtask

  vec_t vecs[8];

  initial begin
    int cyc;
    int sent;
    int pick[$];
    checks = 0; errors = 0; obs_n = 0; obs_first = 0; obs_last = 0;
    reserved_cnt = 0; err_m = 1'b0; last_hs = 1'b0;
    foreach (busy_m[i]) busy_m[i] = 1'b0;
    in_valid = 1'b0; in_addr = '0; in_len = '0;
    out_ready = 1'b1; cpl_valid = 1'b0; cpl_tag = '0; reset = 1'b1;

    vecs[0] = '{64'h1000, 2048, 4, 512, 512, 124};
    vecs[1] = '{64'h11F0, 64, 2, 16, 48, 122};
    vecs[2] = '{64'h2000, 4, 1, 4, 4, 121};
    vecs[3] = '{64'h21FC, 8, 2, 4, 4, 119};
    vecs[4] = '{64'h3100, 768, 2, 256, 512, 117};
    vecs[5] = '{64'h0FFC, 4100, 9, 4, 512, 108};
    vecs[6] = '{64'h4000, 512, 1, 512, 512, 107};
    vecs[7] = '{64'h4004, 512, 2, 508, 4, 105};

    apply_reset();
    tick();

    // Table of single requests with out_ready held high.
    for (int i = 0; i < 8; i++) begin
      obs_n = 0; obs_first = 0; obs_last = 0;
      in_valid = 1'b1; in_addr = vecs[i].addr; in_len = LW'(vecs[i].len);
      tick();
      check("tbl_accept", 64'(last_hs), 64'(1));
      in_valid = 1'b0;
      drain(100);
      check("tbl_nchunks", 64'(obs_n), 64'(vecs[i].n));
      check("tbl_first_len", 64'(obs_first), 64'(vecs[i].first_len));
      check("tbl_last_len", 64'(obs_last), 64'(vecs[i].last_len));
      check("tbl_tags_free", 64'(tags_free), 64'(vecs[i].tags_free));
    end

    // Exhaust the tag pool with a 130-chunk request.
    apply_reset();
    in_valid = 1'b1; in_addr = 64'h0; in_len = LW'(130 * 512);
    tick();
    in_valid = 1'b0;
    cyc = 0;
    while (!(reserved_cnt == NT && !out_valid) && cyc < 300) begin
      tick();
      cyc++;
    end
    check("exh_timeout", 64'(cyc < 300), 64'(1));
    check("exh_tags_free", 64'(tags_free), 64'(0));
    check("exh_out_valid", 64'(out_valid), 64'(0));

    // Releasing tag 2 lets the next chunk go out one cycle later, carrying tag 2.
    cpl_valid = 1'b1; cpl_tag = TW'(2);
    tick();
    cpl_valid = 1'b0;
    check("rel_same_cycle_valid", 64'(out_valid), 64'(0));
    check("rel_tags_free", 64'(tags_free), 64'(1));
    out_ready = 1'b0;
    tick();
    check("rel_out_valid", 64'(out_valid), 64'(1));
    check("rel_out_tag", 64'(out_tag), 64'(2));
    check("rel_out_addr", 64'(out_addr), 64'(128 * 512));

    // Three cycles of backpressure; the model checks the hold each cycle.
    tick();
    tick();
    tick();
    check("bp_out_tag", 64'(out_tag), 64'(2));

    // Drain and release tag 1 in the same cycle with the pool empty.
    out_ready = 1'b1; cpl_valid = 1'b1; cpl_tag = TW'(1);
    tick();
    cpl_valid = 1'b0;
    check("drain_rel_valid", 64'(out_valid), 64'(0));
    tick();
    check("reload_valid", 64'(out_valid), 64'(1));
    check("reload_tag", 64'(out_tag), 64'(1));
    check("reload_last", 64'(out_last), 64'(1));
    check("reload_tags_free", 64'(tags_free), 64'(0));
    tick();

    // Double free of tag 5: first release is legal, the second one flags.
    cpl_valid = 1'b1; cpl_tag = TW'(5);
    tick();
    check("dbl_first_err", 64'(err_dbl_free), 64'(0));
    check("dbl_first_free", 64'(tags_free), 64'(1));
    tick();
    cpl_valid = 1'b0;
    check("dbl_second_err", 64'(err_dbl_free), 64'(1));
    check("dbl_second_free", 64'(tags_free), 64'(1));
    tick();
    check("dbl_sticky", 64'(err_dbl_free), 64'(1));

    // Reset in the middle of an 8-chunk split.
    apply_reset();
    obs_n = 0;
    in_valid = 1'b1; in_addr = 64'h8000; in_len = LW'(4096);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("mid_chunks", 64'(obs_n), 64'(2));
    reset = 1'b1;
    #1;
    check("mid_rst_in_ready", 64'(in_ready), 64'(0));
    tick();
    check("mid_rst_valid", 64'(out_valid), 64'(0));
    check("mid_rst_free", 64'(tags_free), 64'(NT));
    reset = 1'b0;
    #1;
    check("mid_post_in_ready", 64'(in_ready), 64'(1));
    cpl_valid = 1'b1; cpl_tag = TW'(0);
    tick();
    cpl_valid = 1'b0;
    check("mid_stale_cpl_err", 64'(err_dbl_free), 64'(1));

    // Randomized traffic with backpressure and out-of-order tag returns.
    apply_reset();
    sent = 0; cyc = 0;
    in_addr = LW'(0); in_len = LW'(4);
    in_addr = {32'h0, $urandom() & 32'hFFFF_FFFC};
    in_len  = LW'($urandom_range(1, 600) * 4);
    while (!(sent == 40 && exp_q.size() == 0 && !out_valid) && cyc < 20000) begin
      out_ready = ($urandom_range(0, 9) < 7);
      in_valid  = (sent < 40) && ($urandom_range(0, 9) < 8);
      cpl_valid = 1'b0;
      if (reserved_cnt > 0 && $urandom_range(0, 9) < 4) begin
        pick.delete();
        for (int i = 0; i < NT; i++) if (busy_m[i]) pick.push_back(i);
        cpl_valid = 1'b1;
        cpl_tag   = TW'(pick[$urandom_range(0, pick.size() - 1)]);
      end
      tick();
      if (last_hs) begin
        sent++;
        in_addr = {32'h0, $urandom() & 32'hFFFF_FFFC};
        in_len  = LW'($urandom_range(1, 600) * 4);
      end
      cyc++;
    end
    in_valid = 1'b0; cpl_valid = 1'b0;
    check("rand_done", 64'(cyc < 20000), 64'(1));
    check("rand_sent", 64'(sent), 64'(40));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
